// File: rtl/complement_decoder.sv
// Two-lane two's-complement to sign-magnitude converter.
// Two-stage valid/ready pipeline with a single global advance enable,
// per-lane overflow flags for the unrepresentable most-negative input, and
// a saturating count of overflowing lanes delivered downstream.
module complement_decoder #(
   parameter int bitNumber = 7
) (
   input  logic                 clk1,
   input  logic                 rst1,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [bitNumber:0]   A,
   input  logic [bitNumber:0]   B,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [bitNumber:0]   Aout,
   output logic [bitNumber:0]   Bout,
   output logic                 ovfA,
   output logic                 ovfB,
   output logic [15:0]          ovf_count
);

   localparam int W = bitNumber + 1;

   // Returns {ovf, sign-magnitude value}. The most-negative input has no
   // sign-magnitude equivalent, so it saturates to all ones and flags ovf;
   // this also keeps negative zero from ever appearing on the output.
   function automatic logic [W:0] conv(input logic [W-1:0] x);
      logic [W-1:0] neg;
      neg = ~x + 1'b1;
      if (!x[W-1])
         return {1'b0, x};
      else if (x[W-2:0] == '0)
         return {1'b1, {W{1'b1}}};
      else
         return {1'b0, 1'b1, neg[W-2:0]};
   endfunction

   logic           en;
   logic           xfer_out;

   logic           v1_q, v1_d;
   logic [W-1:0]   a1_q, a1_d, b1_q, b1_d;

   logic           v2_q, v2_d;
   logic [W-1:0]   aout_q, aout_d, bout_q, bout_d;
   logic           ovfa_q, ovfa_d, ovfb_q, ovfb_d;

   logic [15:0]    cnt_q, cnt_d;
   logic [16:0]    cnt_sum;

   logic [W:0]     conv_a, conv_b;

   assign en       = !v2_q || out_ready;
   assign xfer_out = v2_q && out_ready;
   assign conv_a   = conv(a1_q);
   assign conv_b   = conv(b1_q);
   assign cnt_sum  = {1'b0, cnt_q} + 17'(ovfa_q) + 17'(ovfb_q);

   // Next-state for both pipeline stages and the overflow counter.
   always_comb begin
      v1_d   = v1_q;
      a1_d   = a1_q;
      b1_d   = b1_q;
      v2_d   = v2_q;
      aout_d = aout_q;
      bout_d = bout_q;
      ovfa_d = ovfa_q;
      ovfb_d = ovfb_q;
      cnt_d  = cnt_q;
      if (en) begin
         v1_d = in_valid;
         v2_d = v1_q;
         if (in_valid) begin
            a1_d = A;
            b1_d = B;
         end
         if (v1_q) begin
            aout_d = conv_a[W-1:0];
            bout_d = conv_b[W-1:0];
            ovfa_d = conv_a[W];
            ovfb_d = conv_b[W];
         end
      end
      if (xfer_out)
         cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   // State registers with synchronous reset that drops all in-flight pairs.
   always_ff @(posedge clk1) begin
      if (rst1) begin
         v1_q   <= 1'b0;
         a1_q   <= '0;
         b1_q   <= '0;
         v2_q   <= 1'b0;
         aout_q <= '0;
         bout_q <= '0;
         ovfa_q <= 1'b0;
         ovfb_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         v1_q   <= v1_d;
         a1_q   <= a1_d;
         b1_q   <= b1_d;
         v2_q   <= v2_d;
         aout_q <= aout_d;
         bout_q <= bout_d;
         ovfa_q <= ovfa_d;
         ovfb_q <= ovfb_d;
         cnt_q  <= cnt_d;
      end
   end

   assign in_ready  = en;
   assign out_valid = v2_q;
   assign Aout      = aout_q;
   assign Bout      = bout_q;
   assign ovfA      = ovfa_q;
   assign ovfB      = ovfb_q;
   assign ovf_count = cnt_q;

endmodule

// File: tb/tb_complement_decoder.sv
// Directed bench for complement_decoder (bitNumber = 7).
module tb_complement_decoder;

   logic        clk1;
   logic        rst1;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  A, B;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  Aout, Bout;
   logic        ovfA, ovfB;
   logic [15:0] ovf_count;

   complement_decoder #(.bitNumber(7)) dut (
      .clk1      (clk1),
      .rst1      (rst1),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Aout      (Aout),
      .Bout      (Bout),
      .ovfA      (ovfA),
      .ovfB      (ovfB),
      .ovf_count (ovf_count)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       oa;
      logic       ob;
   } vec_t;

   vec_t vecs [8];

   int n_vec = 0;
   int n_err = 0;
   int model_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   initial begin
      int sent, rcvd, any_out;
      logic       stall_prev;
      logic [7:0] pa, pb;
      logic       poa, pob, pv;
      logic [7:0] eb;

      vecs[0] = '{8'hFB, 8'h05, 8'h85, 8'h05, 1'b0, 1'b0};
      vecs[1] = '{8'h80, 8'h80, 8'hFF, 8'hFF, 1'b1, 1'b1};
      vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'h81, 1'b0, 1'b0};
      vecs[3] = '{8'h7F, 8'h81, 8'h7F, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{8'h01, 8'hFE, 8'h01, 8'h82, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 8'h7F, 8'hFF, 8'h7F, 1'b1, 1'b0};
      vecs[6] = '{8'hC0, 8'h80, 8'hC0, 8'hFF, 1'b0, 1'b1};
      vecs[7] = '{8'h90, 8'h00, 8'hF0, 8'h00, 1'b0, 1'b0};

      rst1 = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_aout", 32'(Aout), 0);
      chk("rst_bout", 32'(Bout), 0);
      chk("rst_ovf", 32'({ovfA, ovfB}), 0);
      chk("rst_count", 32'(ovf_count), 0);
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      out_ready = 1'b1;
      rst1 = 1'b0;
      step();

      // Single pairs through an idle pipe: two-cycle latency and conversion.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; A = vecs[i].a; B = vecs[i].b;
         step();
         in_valid = 1'b0;
         step();
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 1);
         chk($sformatf("v%0d_aout", i), 32'(Aout), 32'(vecs[i].ea));
         chk($sformatf("v%0d_bout", i), 32'(Bout), 32'(vecs[i].eb));
         chk($sformatf("v%0d_ovfa", i), 32'(ovfA), 32'(vecs[i].oa));
         chk($sformatf("v%0d_ovfb", i), 32'(ovfB), 32'(vecs[i].ob));
         chk($sformatf("v%0d_count", i), 32'(ovf_count), 32'(model_cnt));
         model_cnt += int'(vecs[i].oa) + int'(vecs[i].ob);
         step();
         chk($sformatf("v%0d_drained", i), 32'(out_valid), 0);
         chk($sformatf("v%0d_count_after", i), 32'(ovf_count), 32'(model_cnt));
      end

      // Back-to-back stream with out_ready toggling every cycle.
      sent = 0; rcvd = 0; stall_prev = 1'b0;
      pa = '0; pb = '0; poa = 1'b0; pob = 1'b0; pv = 1'b0;
      for (int cyc = 0; cyc < 1000 && rcvd < 64; cyc++) begin
         out_ready = cyc[0];
         in_valid  = (sent < 64);
         A = 8'(sent);
         B = 8'(-sent);
         #1;
         if (stall_prev) begin
            chk("stall_hold_valid", 32'(out_valid), 32'(pv));
            chk("stall_hold_aout", 32'(Aout), 32'(pa));
            chk("stall_hold_bout", 32'(Bout), 32'(pb));
            chk("stall_hold_ovf", 32'({ovfA, ovfB}), 32'({poa, pob}));
         end
         if (out_valid && !out_ready)
            chk("stall_in_ready", 32'(in_ready), 0);
         if (out_valid && out_ready) begin
            eb = (rcvd == 0) ? 8'h00 : {1'b1, 7'(rcvd)};
            chk($sformatf("stream%0d_aout", rcvd), 32'(Aout), 32'(rcvd));
            chk($sformatf("stream%0d_bout", rcvd), 32'(Bout), 32'(eb));
            chk($sformatf("stream%0d_ovf", rcvd), 32'({ovfA, ovfB}), 0);
            rcvd++;
         end
         if (in_valid && in_ready) sent++;
         stall_prev = out_valid && !out_ready;
         pa = Aout; pb = Bout; poa = ovfA; pob = ovfB; pv = out_valid;
         step();
      end
      in_valid = 1'b0;
      chk("stream_received", 32'(rcvd), 64);
      chk("stream_count", 32'(ovf_count), 32'(model_cnt));

      // Reset with two overflowing pairs held in flight.
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      in_valid = 1'b1; A = 8'h80; B = 8'h80;
      step();
      step();
      in_valid = 1'b0;
      chk("inflight_out_valid", 32'(out_valid), 1);
      chk("inflight_in_ready", 32'(in_ready), 0);
      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      model_cnt = 0;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_count", 32'(ovf_count), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_aout", 32'(Aout), 0);
      out_ready = 1'b1;
      any_out = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid) any_out++;
         step();
      end
      chk("midrst_no_ghost", 32'(any_out), 0);
      in_valid = 1'b1; A = 8'hFB; B = 8'h05;
      step();
      in_valid = 1'b0;
      step();
      chk("postrst_out_valid", 32'(out_valid), 1);
      chk("postrst_aout", 32'(Aout), 32'h85);
      chk("postrst_bout", 32'(Bout), 32'h05);
      step();

      // Saturation: stream most-negative pairs past 16'hFFFF.
      out_ready = 1'b1;
      A = 8'h80; B = 8'h80;
      for (int c = 0; c < 33010; c++) begin
         in_valid = (c < 33000);
         #1;
         if (out_valid && out_ready)
            model_cnt = (model_cnt + 2 > 65535) ? 65535 : model_cnt + 2;
         step();
      end
      chk("sat_model_count", 32'(ovf_count), 32'(model_cnt));
      chk("sat_count", 32'(ovf_count), 32'hFFFF);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("sat_hold", 32'(ovf_count), 32'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
